// File: rtl/acc_stack.sv
// Accumulator with a small LIFO save stack. A control code on cs selects
// load, clear, push, pop, swap or flush. Illegal stack operations raise a sticky error flag.
module acc_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4:0]                   cs,
  input  logic [WIDTH-1:0]             datoin,
  output logic [WIDTH-1:0]             a,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [4:0] {
    OP_LOAD  = 5'b10001,
    OP_CLRA  = 5'b10010,
    OP_PUSH  = 5'b11100,
    OP_POP   = 5'b11101,
    OP_SWAP  = 5'b11110,
    OP_FLUSH = 5'b11111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] top_val;
  logic             full_w, empty_w;

  assign op      = op_e'(cs);
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Top of stack is entry[count-1]. Stale entries beyond count stay hidden.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top_val = mem_q[i];
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    a_d     = a_q;
    count_d = count_q;
    err_d   = err_q;
    mem_d   = mem_q;
    case (op)
      OP_LOAD:  a_d = datoin;
      OP_CLRA:  a_d = '0;
      OP_PUSH: begin
        if (full_w) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i)) mem_d[i] = a_q;
          end
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_w) begin
          err_d = 1'b1;
        end else begin
          a_d     = top_val;
          count_d = count_q - CW'(1);
        end
      end
      OP_SWAP: begin
        if (empty_w) begin
          err_d = 1'b1;
        end else begin
          a_d = top_val;
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) mem_d[i] = a_q;
          end
        end
      end
      OP_FLUSH: begin
        count_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: the entries are in the async reset because reset must leave all of them at zero. Nonblocking assignments keep every register update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      a_q     <= a_d;
      count_q <= count_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign a     = a_q;
  assign top   = top_val;
  assign count = count_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign err   = err_q;

endmodule

// File: doc/acc_stack.md
ACC_STACK -- requirements
Module: acc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the data width of the accumulator and the stack entries (legal range 1..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of save-stack entries (legal range 1..16).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port cs  input  5  meaning the control code, decoded every cycle.
REQ-006 SHALL have port datoin  input  WIDTH  meaning the load data.
REQ-007 SHALL have port a  output  WIDTH  meaning the registered accumulator.
REQ-008 SHALL have port top  output  WIDTH  meaning the current top-of-stack entry, or 0 when the stack is empty.
REQ-009 SHALL have port count  output  $clog2(DEPTH+1)  meaning the number of occupied stack entries.
REQ-010 SHALL have port full  output  1  meaning count equals DEPTH.
REQ-011 SHALL have port empty  output  1  meaning count equals 0.
REQ-012 SHALL have port err  output  1  meaning a sticky illegal-operation flag.

Function
REQ-013 SHALL decode cs as follows: 10001 LOAD, 10010 CLRA, 11100 PUSH, 11101 POP, 11110 SWAP, 11111 FLUSH; all other codes are NOP and hold all state.
REQ-014 SHALL, on LOAD, set a to datoin at the next edge (1-cycle latency).
REQ-015 SHALL, on CLRA, set a to 0; stack and err unchanged.
REQ-016 SHALL, on PUSH when not full, write a into entry[count] and increment count; a unchanged.
REQ-017 SHALL, on PUSH when full, leave a, count and all entries unchanged and set err.
REQ-018 SHALL, on POP when not empty, load a from entry[count-1] and decrement count.
REQ-019 SHALL, on POP when empty, leave a and count unchanged and set err.
REQ-020 SHALL, on SWAP when not empty, exchange a and entry[count-1] in one edge; count unchanged.
REQ-021 SHALL, on SWAP when empty, leave all state unchanged and set err.
REQ-022 SHALL, on FLUSH, set count to 0 and clear err; a unchanged; entry contents need not be cleared but SHALL be invisible (top = 0).
REQ-023 SHALL keep err set once raised until FLUSH or reset; a successful operation SHALL NOT clear it.
REQ-024 SHALL derive top, full and empty combinationally from registered state only, with no path from cs or datoin.
REQ-025 SHALL never let count exceed DEPTH or wrap below 0.
REQ-026 SHALL treat DEPTH=1 correctly: PUSH fills the stack, and a second PUSH sets err.

Reset
REQ-027 SHALL, while reset=0, force a=0, count=0, err=0 and all entries to 0 immediately, independent of clk.
REQ-028 SHALL, when reset asserts mid-sequence, discard any operation on that edge; the first operation after release SHALL act on the reset state.
REQ-029 SHALL, immediately after reset, present top=0, empty=1 and full=0.

Verification (WIDTH=4, DEPTH=4)
REQ-030 Bench SHALL apply reset pulse low then LOAD 0x5 -> a=0x5 one cycle later, empty=1, err=0.
REQ-031 Bench SHALL apply LOAD/PUSH of 1,2,3,4 then PUSH 0x9 -> count=4, full=1, top=4, err=1, entries unchanged.
REQ-032 Bench SHALL apply POP x4 after the previous scenario -> a=4,3,2,1 in successive cycles, count=0, empty=1; then one more POP -> a stays 1 and err stays 1.
REQ-033 Bench SHALL apply FLUSH, LOAD 0xA, PUSH, LOAD 0x3, SWAP -> a=0xA, top=0x3, count=1, err=0.
REQ-034 Bench SHALL drive undefined cs codes (00000, 10011) for 3 cycles -> all outputs held.
REQ-035 Bench SHALL assert reset between clock edges while count=2 -> outputs go to their reset values before the next edge, and a PUSH in the first cycle after release gives count=1, top=0.
